pipelined_add_sub: RTL and testbench
====================================

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter STAGE_BITS, default 4, bits added per pipeline stage; NUM_STAGES = WIDTH/STAGE_BITS.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands and op_sub valid this cycle.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand.
REQ-009 op_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result, carry, overflow valid.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 Result  output  WIDTH  sum/difference modulo 2^WIDTH.
REQ-013 Carry  output  1  unsigned carry-out of the WIDTH-bit add; for subtract, 1 = no borrow.
REQ-014 Overflow  output  1  two's-complement signed overflow.

Function
REQ-015 Accept an operation at a rising edge iff in_valid and in_ready are both 1.
REQ-016 Subtract computed as A + ~B + 1: B inverted, carry-in 1 into the least-significant slice.
REQ-017 Stage i adds bits [i*STAGE_BITS +: STAGE_BITS] of A and B' (B' = B or ~B) with registered carry from stage i-1; carry ripples one stage per cycle.
REQ-018 Unconsumed upper operand slices delayed by input skew registers; completed lower result slices delayed by output deskew registers so all slices of one operation emerge together.
REQ-019 Latency: operation accepted at edge k yields out_valid=1 with its Result/Carry/Overflow after edge k+NUM_STAGES-1 (WIDTH=4, STAGE_BITS=4: after edge k).
REQ-020 Carry = carry-out of the top slice; Overflow = carry-in XOR carry-out of bit WIDTH-1.
REQ-021 Pipeline advance enable = ~out_valid | out_ready; all stage registers, including valid bits, hold when enable is 0.
REQ-022 in_ready = advance enable (combinational from out_valid and out_ready; no path from in_valid).
REQ-023 Stages carry a valid bit; bubbles propagate; out_valid = valid bit of last stage.
REQ-024 Throughput one operation per cycle while out_ready=1; order preserved; no loss, no duplication.
REQ-025 Output held stable (Result, Carry, Overflow, out_valid) while out_valid=1 and out_ready=0.
REQ-026 Simultaneous accept and output consume in the same cycle allowed; both take effect at that edge.
REQ-027 Data fields of invalid stages are don't-care but must not be X after reset.
REQ-028 WIDTH not a positive multiple of STAGE_BITS: elaboration-time error.

Reset
REQ-029 rst_n=0 clears all valid bits immediately (out_valid=0, in_ready=1) without waiting for clk.
REQ-030 All data, carry and skew registers reset to 0; Result=0, Carry=0, Overflow=0 during reset.
REQ-031 Reset mid-operation discards every in-flight operation; none emerges after rst_n returns to 1.
REQ-032 First operation is acceptable at the first rising edge with rst_n=1.

Structure
REQ-033 Shared package add_sub_pkg holds default WIDTH, STAGE_BITS and the NUM_STAGES derivation function.
REQ-034 One sub-module adder_slice: STAGE_BITS-wide combinational add with carry-in, carry-out and top-bit carry-in (for overflow); instantiated NUM_STAGES times by generate.
REQ-035 Pipeline, skew and deskew registers and handshake logic reside in pipelined_add_sub.

Verification
REQ-036 WIDTH=16: add 0xFFFF+0x0001 accepted at edge k -> after edge k+3 Result=0x0000, Carry=1, Overflow=0.
REQ-037 Add 0x7FFF+0x0001 -> Result=0x8000, Carry=0, Overflow=1; subtract 0x0003-0x0005 -> Result=0xFFFE, Carry=0, Overflow=0.
REQ-038 8 back-to-back ops, out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during stall, outputs stable, all 8 results in order, none duplicated.
REQ-039 rst_n pulsed low asynchronously with 3 ops in flight -> out_valid=0 at once; no result appears after release; next op returns correct value with normal latency.
REQ-040 WIDTH=4, STAGE_BITS=4: exhaustive 256 operand pairs x both modes -> each matches reference model with 1-edge latency.
REQ-041 Random in_valid/out_ready, WIDTH=32, STAGE_BITS=8, 10000 ops -> scoreboard match on Result, Carry, Overflow.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared defaults and stage-count derivation
// for the pipelined adder/subtractor.
package add_sub_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_STAGE_BITS = 4;

  function automatic int num_stages(
    input int width,
    input int stage_bits
  );
    return (stage_bits > 0) ? width / stage_bits : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One combinational carry slice; ctop is the
// carry into the slice's top bit.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ctop
);

  logic [W:0] t;

  assign t    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = t[W-1:0];
  assign cout = t[W];
  assign ctop = a[W-1] ^ b[W-1] ^ t[W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Carry-pipelined add/sub: one slice per stage,
// skewed operands in, deskewed result out.
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STAGE_BITS = DEF_STAGE_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SB = STAGE_BITS;
  localparam int NS = num_stages(WIDTH, STAGE_BITS);

  if (SB < 1 || WIDTH < SB || (WIDTH % SB) != 0) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of STAGE_BITS");
  end

  logic en;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar i = 0; i < NS; i++) begin : g_st
    localparam int RW = (i + 1) * SB;

    logic [SB-1:0] op_a, op_b, sum;
    logic          cin, cout, ctop;
    logic          v_d, v_q, c_q;
    logic [RW-1:0] r_d, r_q;

    if (i == 0) begin : g_src
      assign op_a = A[SB-1:0];
      assign op_b = B[SB-1:0] ^ {SB{op_sub}};
      assign cin  = op_sub;
      assign v_d  = in_valid;
      assign r_d  = sum;
    end else begin : g_src
      assign op_a = g_st[i-1].g_skew.a_q[SB-1:0];
      assign op_b = g_st[i-1].g_skew.b_q[SB-1:0];
      assign cin  = g_st[i-1].c_q;
      assign v_d  = g_st[i-1].v_q;
      assign r_d  = {sum, g_st[i-1].r_q};
    end

    adder_slice #(.W(SB)) u_slice (
      .a    (op_a),
      .b    (op_b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .ctop (ctop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (en) begin
        v_q <= v_d;
        c_q <= cout;
        r_q <= r_d;
      end
    end

    // upper slices not yet consumed ride along, B already inverted
    if (i < NS - 1) begin : g_skew
      localparam int AW = WIDTH - RW;

      logic [AW-1:0] a_d, b_d, a_q, b_q;
      logic          unused_ctop;

      assign unused_ctop = ctop;

      if (i == 0) begin : g_in
        assign a_d = A[WIDTH-1:SB];
        assign b_d = B[WIDTH-1:SB] ^ {AW{op_sub}};
      end else begin : g_in
        assign a_d = g_st[i-1].g_skew.a_q[AW+SB-1:SB];
        assign b_d = g_st[i-1].g_skew.b_q[AW+SB-1:SB];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ov_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (en) begin
          ov_q <= ctop ^ cout;
        end
      end
    end
  end

  assign out_valid = g_st[NS-1].v_q;
  assign Result    = g_st[NS-1].r_q;
  assign Carry     = g_st[NS-1].c_q;
  assign Overflow  = g_st[NS-1].g_last.ov_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three configurations
// against an arithmetic reference model.
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        iv0, ir0, ovl0, ordy0, s0, cy0, of0;
  logic [3:0]  a0, b0, res0;
  logic        iv1, ir1, ovl1, ordy1, s1, cy1, of1;
  logic [15:0] a1, b1, res1;
  logic        iv2, ir2, ovl2, ordy2, s2, cy2, of2;
  logic [31:0] a2, b2, res2;

  pipelined_add_sub #(.WIDTH(4), .STAGE_BITS(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0),
    .A(a0), .B(b0), .op_sub(s0),
    .out_valid(ovl0), .out_ready(ordy0),
    .Result(res0), .Carry(cy0), .Overflow(of0)
  );

  pipelined_add_sub #(.WIDTH(16), .STAGE_BITS(4)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .A(a1), .B(b1), .op_sub(s1),
    .out_valid(ovl1), .out_ready(ordy1),
    .Result(res1), .Carry(cy1), .Overflow(of1)
  );

  pipelined_add_sub #(.WIDTH(32), .STAGE_BITS(8)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(ir2),
    .A(a2), .B(b2), .op_sub(s2),
    .out_valid(ovl2), .out_ready(ordy2),
    .Result(res2), .Carry(cy2), .Overflow(of2)
  );

  typedef struct {
    longint unsigned res;
    bit              c;
    bit              o;
    int              cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          s;
    logic [15:0] r;
    bit          c;
    bit          o;
  } vec_t;

  int              checks = 0;
  int              errors = 0;
  int              cyc_n  = 0;
  int              npop   = 0;
  bit              lat_on = 1'b1;
  exp_t            sb[$];
  longint unsigned last_r;
  bit              last_c, last_o;

  function automatic int wd(int d);
    return (d == 0) ? 4 : (d == 1) ? 16 : 32;
  endfunction

  function automatic int ns(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // plain integer arithmetic: wraparound, unsigned carry, signed range
  function automatic exp_t model(int w, longint unsigned a,
                                 longint unsigned b, bit s);
    exp_t            e;
    longint unsigned m, am, bm;
    longint          sa, sbv, sr, half;
    m    = 64'd1 << w;
    half = longint'(m / 2);
    am   = a & (m - 1);
    bm   = b & (m - 1);
    sa   = (longint'(am) >= half) ? longint'(am) - longint'(m) : longint'(am);
    sbv  = (longint'(bm) >= half) ? longint'(bm) - longint'(m) : longint'(bm);
    sr   = s ? sa - sbv : sa + sbv;
    e.res = (s ? am - bm : am + bm) & (m - 1);
    e.c   = s ? (am >= bm) : ((am + bm) >= m);
    e.o   = (sr >= half) || (sr < -half);
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc_n);
    end
  endtask

  task automatic drive(int d, bit iv, bit ordy, longint unsigned a,
                       longint unsigned b, bit s);
    case (d)
      0: begin
        iv0 = iv; ordy0 = ordy; a0 = a[3:0]; b0 = b[3:0]; s0 = s;
      end
      1: begin
        iv1 = iv; ordy1 = ordy; a1 = a[15:0]; b1 = b[15:0]; s1 = s;
      end
      default: begin
        iv2 = iv; ordy2 = ordy; a2 = a[31:0]; b2 = b[31:0]; s2 = s;
      end
    endcase
  endtask

  task automatic sample(int d, output bit ir, output bit ovl,
                        output longint unsigned r, output bit c,
                        output bit o);
    case (d)
      0: begin ir = ir0; ovl = ovl0; r = 64'(res0); c = cy0; o = of0; end
      1: begin ir = ir1; ovl = ovl1; r = 64'(res1); c = cy1; o = of1; end
      default: begin
        ir = ir2; ovl = ovl2; r = 64'(res2); c = cy2; o = of2;
      end
    endcase
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic cycle(int d, bit iv, bit ordy, longint unsigned a,
                       longint unsigned b, bit s, output bit acc);
    bit              ir, ovl, c, o;
    longint unsigned r;
    exp_t            e;
    drive(d, iv, ordy, a, b, s);
    #1;
    sample(d, ir, ovl, r, c, o);
    chk("in_ready", 64'(ir), 64'(!ovl || ordy));
    acc = iv && ir;
    if (ovl && !ordy) begin
      if (sb.size() > 0) begin
        chk("hold_res", r, sb[0].res);
        chk("hold_carry", 64'(c), 64'(sb[0].c));
        chk("hold_ovf", 64'(o), 64'(sb[0].o));
      end else begin
        chk("spurious_valid", 64'(ovl), 64'(0));
      end
    end else if (ovl) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(ovl), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("result", r, e.res);
        chk("carry", 64'(c), 64'(e.c));
        chk("overflow", 64'(o), 64'(e.o));
        if (lat_on) chk("latency", 64'(cyc_n - e.cyc), 64'(ns(d)));
        npop++;
        last_r = r;
        last_c = c;
        last_o = o;
      end
    end
    if (acc) begin
      e     = model(wd(d), a, b, s);
      e.cyc = cyc_n;
      sb.push_back(e);
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drain(int d, int maxc);
    bit acc;
    for (int n = 0; n < maxc && sb.size() > 0; n++)
      cycle(d, 1'b0, 1'b1, 0, 0, 1'b0, acc);
    if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            tbl[12];
    bit              acc, ir, ovl, c, o;
    longint unsigned r;
    int              base, sent;

    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2]  = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[5]  = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[9]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[11] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 0, 0, 1'b0);
    #3;
    for (int d = 0; d < 3; d++) begin
      sample(d, ir, ovl, r, c, o);
      chk("reset_out_valid", 64'(ovl), 64'(0));
      chk("reset_in_ready", 64'(ir), 64'(1));
      chk("reset_result", r, 64'(0));
      chk("reset_carry", 64'(c), 64'(0));
      chk("reset_ovf", 64'(o), 64'(0));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vectors, first one at the first edge out of reset
    lat_on = 1'b1;
    foreach (tbl[i]) begin
      base = npop;
      cycle(1, 1'b1, 1'b1, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].s, acc);
      chk("tbl_accept", 64'(acc), 64'(1));
      drain(1, 10);
      chk("tbl_pops", 64'(npop - base), 64'(1));
      chk("tbl_result", last_r, 64'(tbl[i].r));
      chk("tbl_carry", 64'(last_c), 64'(tbl[i].c));
      chk("tbl_ovf", 64'(last_o), 64'(tbl[i].o));
    end

    // 8 back-to-back ops with a 3-cycle output stall
    lat_on = 1'b0;
    base   = npop;
    sent   = 0;
    for (int n = 0; n < 40 && (sent < 8 || sb.size() > 0); n++) begin
      cycle(1, sent < 8, !(n >= 5 && n <= 7), 64'($urandom),
            64'($urandom), 1'($urandom & 1), acc);
      if (acc) sent++;
    end
    chk("stall_sent", 64'(sent), 64'(8));
    chk("stall_pops", 64'(npop - base), 64'(8));

    // async reset with three operations in flight
    lat_on = 1'b1;
    for (int n = 0; n < 3; n++)
      cycle(1, 1'b1, 1'b1, 64'($urandom), 64'($urandom),
            1'($urandom & 1), acc);
    #2 rst_n = 1'b0;
    #1;
    sample(1, ir, ovl, r, c, o);
    chk("midrst_out_valid", 64'(ovl), 64'(0));
    chk("midrst_in_ready", 64'(ir), 64'(1));
    chk("midrst_result", r, 64'(0));
    drive(1, 1'b0, 1'b1, 0, 0, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    base = npop;
    for (int n = 0; n < 8; n++) cycle(1, 1'b0, 1'b1, 0, 0, 1'b0, acc);
    cycle(1, 1'b1, 1'b1, 64'h1234, 64'h0234, 1'b1, acc);
    drain(1, 10);
    chk("post_rst_pops", 64'(npop - base), 64'(1));
    chk("post_rst_result", last_r, 64'h1000);
    chk("post_rst_carry", 64'(last_c), 64'(1));

    // WIDTH=4 single stage: every operand pair, both modes, streamed
    lat_on = 1'b1;
    base   = npop;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 2; s++)
          cycle(0, 1'b1, 1'b1, 64'(a), 64'(b), s[0], acc);
    drain(0, 5);
    chk("exh_pops", 64'(npop - base), 64'(512));

    // WIDTH=32: random handshakes against the scoreboard
    lat_on = 1'b0;
    base   = npop;
    sent   = 0;
    for (int n = 0; n < 40000 && sent < 10000; n++) begin
      cycle(2, ($urandom % 4) != 0, ($urandom % 4) != 0,
            64'($urandom), 64'($urandom), 1'($urandom & 1), acc);
      if (acc) sent++;
    end
    chk("rand_sent", 64'(sent), 64'(10000));
    drain(2, 20);
    chk("rand_pops", 64'(npop - base), 64'(10000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
